mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control unit for the next-generation LEGv8 core, replacing the single-cycle decoder so that one shared memory port and one ALU are reused across cycles. It decodes `opcode` (instruction[31:21]), sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, and drives every datapath mux and enable. It adds a req/ack memory handshake with a bounded wait timeout, a sticky fault state for illegal opcodes and timeouts, and a retired-instruction counter.

## Interface
- `TIMEOUT`, 16, maximum consecutive cycles with `mem_req`=1 and `mem_ack`=0 before fault (≥1)
- `COUNT_W`, 32, width of `retired`
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  11  instruction[31:21] from the IR
- `zero`  in  1  ALU zero flag
- `mem_ack`  in  1  memory transfer complete this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = write (STUR)
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `ir_write`, `pc_write`, `reg_write`  out  1 each  register enables
- `reg2loc`  out  1  read register 2 = instruction[4:0] when 1
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR
- `alu_src_a`  out  1  0 = PC, 1 = readData1
- `alu_src_b`  out  2  00 readData2, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- `alu_op`  out  2  00 add, 01 pass B / compare, 10 function from opcode
- `pc_src`  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- `state`  out  4  current state encoding (debug)
- `fault`  out  1  sticky fault indicator
- `retired`  out  COUNT_W  instructions completed since reset, wraps

## Operation
- Decode classes: R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx; anything else is illegal.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00. On `mem_ack`: `ir_write`=1 and `pc_write`=1 in that cycle, go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut), `reg2loc`=1 for STUR/CBZ/CBNZ. Next: R→EXEC_R, LDUR/STUR→ADDR, CBZ/CBNZ→BRANCH, B→JUMP, illegal→FAULT.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → WB_R. WB_R: `reg_write`=1, `mem_to_reg`=0 → FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: `mem_req`=1, `iord`=1; on ack → WB_MEM. WB_MEM: `reg_write`=1, `mem_to_reg`=1 → FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1, `reg2loc`=1; on ack → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01; `pc_write` = `zero` (CBZ) or `!zero` (CBNZ) → FETCH.
- JUMP: `pc_src`=10, `pc_write`=1 → FETCH.
- FAULT: all enables and `mem_req` 0, `fault`=1; held until reset.
- `retired` increments by 1 on the final cycle of each instruction (WB_R, WB_MEM, MEM_WR on ack, BRANCH, JUMP) and wraps from 2^COUNT_W−1 to 0. Faulting instructions are not counted.
- Outputs are a combinational (Moore, plus `mem_ack`/`zero` qualification) function of state; the output code of every signal not listed for a state is 0.

## Timing
- Reset (async assert, sync-to-clock release): state=FETCH, `fault`=0, `retired`=0, wait counter=0; outputs take FETCH values immediately.
- `mem_ack` is sampled in the same cycle as `mem_req`; a zero-wait ack completes the access in 1 cycle. `mem_ack` outside a memory state is ignored.
- Minimum latency (zero-wait memory): R 4, LDUR 5, STUR 4, CBZ/CBNZ 3, B 3 cycles. Each wait cycle adds 1.
- Wait counter: cleared on entering any memory state and on ack; increments each cycle with `mem_req`=1 and `mem_ack`=0. When it reaches TIMEOUT, the next state is FAULT (ack arriving in that same cycle wins).
- Reset asserted mid-instruction aborts it with no enables issued; `retired` clears.

## Test plan
- Reset low, then high, with ack tied 1; ADD opcode → states FETCH, DECODE, EXEC_R, WB_R; `reg_write`=1 in cycle 4 only; `retired`=1.
- LDUR with 2 wait cycles on data read → 7 cycles total; `mem_to_reg`=1 and `reg_write`=1 in WB_MEM; `iord`=1 during MEM_RD.
- CBZ with zero=1 → `pc_write`=1 and `pc_src`=01 in BRANCH; CBNZ with zero=1 → `pc_write`=0; both increment `retired`.
- Opcode 11111111111 → FAULT after DECODE; `fault`=1, no `mem_req` for 20 cycles; `retired` is unchanged.
- TIMEOUT=4, ack held 0 in FETCH → FAULT after 4 wait cycles; repeat with ack on the 4th cycle → DECODE.
- Preload `retired` near wrap (COUNT_W=4, 16 B instructions) → wraps to 0; async reset pulse in MEM_WR → FETCH immediately, `mem_we`=0.

Source files
------------

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle LEGv8 control FSM with memory handshake timeout, sticky fault and retire counter
module mc_control #(
    parameter int TIMEOUT = 16,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        opcode,
    input  logic               zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               reg2loc,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [3:0]         state,
    output logic               fault,
    output logic [COUNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_WB_R   = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_WB_MEM = 4'd6;
    localparam logic [3:0] S_MEM_WR = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_FAULT  = 4'd10;

    logic [3:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_full;
    logic              retire;
    logic              is_r, is_ldur, is_stur, is_cbz, is_cbnz, is_b;

    // opcode comes straight from the IR, which only changes in FETCH
    always_comb begin
        is_r    = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                  (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
        is_ldur = (opcode == 11'b11111000010);
        is_stur = (opcode == 11'b11111000000);
        is_cbz  = (opcode[10:3] == 8'b10110100);
        is_cbnz = (opcode[10:3] == 8'b10110101);
        is_b    = (opcode[10:5] == 6'b000101);
    end

    assign wait_full = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign fault     = (state == S_FAULT);

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg2loc    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_full) begin
                    next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                reg2loc   = is_stur || is_cbz || is_cbnz;
                if (is_r)                 next_state = S_EXEC_R;
                else if (is_ldur || is_stur) next_state = S_ADDR;
                else if (is_cbz || is_cbnz)  next_state = S_BRANCH;
                else if (is_b)            next_state = S_JUMP;
                else                      next_state = S_FAULT;
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = is_stur ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack)        next_state = S_WB_MEM;
                else if (wait_full) next_state = S_FAULT;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                reg2loc = 1'b1;
                if (mem_ack) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (wait_full) begin
                    next_state = S_FAULT;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = is_cbnz ? !zero : zero;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FAULT;
        endcase
    end

    // the counter idles at zero outside memory states, so entry into one starts from zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= next_state;
            if (mem_req && !mem_ack) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                     wait_cnt <= '0;
            if (retire) retired <= retired + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed-vector bench for mc_control
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg2loc, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic        fault;
    logic [3:0]  retired;
    logic [15:0] ctl;

    int total = 0;
    int passed = 0;

    mc_control #(.TIMEOUT(4), .COUNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .reg2loc(reg2loc),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .state(state), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg2loc, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, fault};

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_WB_R = 4'd3,
                           S_ADDR = 4'd4, S_MEM_RD = 4'd5, S_WB_MEM = 4'd6, S_MEM_WR = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_FAULT = 4'd10;

    // {mem_req,mem_we,iord,ir_write,pc_write,reg_write,reg2loc,mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_src,fault}
    localparam logic [15:0] C_FETCH_W = 16'h8020, C_FETCH_A = 16'h9820, C_DEC = 16'h0060,
                            C_DEC_RL = 16'h0260, C_EXEC_R = 16'h0090, C_WB_R = 16'h0400,
                            C_ADDR = 16'h00C0, C_MEM_RD = 16'hA000, C_WB_MEM = 16'h0500,
                            C_MEM_WR = 16'hE200, C_BR_T = 16'h088A, C_BR_N = 16'h008A,
                            C_JUMP = 16'h0804, C_FAULT = 16'h0001;

    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                            OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                            OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                            OP_CBZ = 11'b10110100101, OP_CBNZ = 11'b10110101010,
                            OP_B = 11'b00010111111, OP_BAD = 11'b11111111111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step(input string tag, input logic [10:0] op, input logic z, input logic ack,
                        input logic [3:0] es, input logic [15:0] ec);
        @(negedge clk);
        opcode = op; zero = z; mem_ack = ack;
        #1;
        chk({tag, ".st"}, 32'(state), 32'(es));
        chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
    endtask

    task automatic ret_after(input string tag, input int n);
        @(posedge clk);
        #1;
        chk({tag, ".ret"}, 32'(retired), 32'(n));
    endtask

    // asynchronous pulse between clock edges
    task automatic pulse_reset(input string tag);
        #1;
        mem_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk({tag, ".st"}, 32'(state), 32'(S_FETCH));
        chk({tag, ".ctl"}, 32'(ctl), 32'(C_FETCH_W));
        chk({tag, ".ret"}, 32'(retired), 32'd0);
        #1;
        reset = 1'b1;
    endtask

    task automatic run_b(input string tag, input int n);
        step({tag, ".f"}, OP_B, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step({tag, ".d"}, OP_B, 1'b0, 1'b1, S_DECODE, C_DEC);
        step({tag, ".j"}, OP_B, 1'b0, 1'b1, S_JUMP, C_JUMP);
        ret_after(tag, n);
    endtask

    task automatic run_r(input string tag, input logic [10:0] op, input int n);
        step({tag, ".f"}, op, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step({tag, ".d"}, op, 1'b0, 1'b1, S_DECODE, C_DEC);
        step({tag, ".x"}, op, 1'b0, 1'b1, S_EXEC_R, C_EXEC_R);
        step({tag, ".w"}, op, 1'b0, 1'b1, S_WB_R, C_WB_R);
        ret_after(tag, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        pulse_reset("rst0");

        run_r("add", OP_ADD, 1);

        step("ld.f", OP_LDUR, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step("ld.d", OP_LDUR, 1'b0, 1'b1, S_DECODE, C_DEC);
        step("ld.a", OP_LDUR, 1'b0, 1'b0, S_ADDR, C_ADDR);
        step("ld.m1", OP_LDUR, 1'b0, 1'b0, S_MEM_RD, C_MEM_RD);
        step("ld.m2", OP_LDUR, 1'b0, 1'b0, S_MEM_RD, C_MEM_RD);
        step("ld.m3", OP_LDUR, 1'b0, 1'b1, S_MEM_RD, C_MEM_RD);
        step("ld.w", OP_LDUR, 1'b0, 1'b1, S_WB_MEM, C_WB_MEM);
        ret_after("ld", 2);

        step("cbz.f", OP_CBZ, 1'b1, 1'b1, S_FETCH, C_FETCH_A);
        step("cbz.d", OP_CBZ, 1'b1, 1'b1, S_DECODE, C_DEC_RL);
        step("cbz.b", OP_CBZ, 1'b1, 1'b1, S_BRANCH, C_BR_T);
        ret_after("cbz", 3);

        step("cbnz.f", OP_CBNZ, 1'b1, 1'b1, S_FETCH, C_FETCH_A);
        step("cbnz.d", OP_CBNZ, 1'b1, 1'b1, S_DECODE, C_DEC_RL);
        step("cbnz.b", OP_CBNZ, 1'b1, 1'b1, S_BRANCH, C_BR_N);
        ret_after("cbnz", 4);

        step("st.f", OP_STUR, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step("st.d", OP_STUR, 1'b0, 1'b1, S_DECODE, C_DEC_RL);
        step("st.a", OP_STUR, 1'b0, 1'b0, S_ADDR, C_ADDR);
        step("st.m1", OP_STUR, 1'b0, 1'b0, S_MEM_WR, C_MEM_WR);
        step("st.m2", OP_STUR, 1'b0, 1'b1, S_MEM_WR, C_MEM_WR);
        ret_after("st", 5);

        run_b("b", 6);
        run_r("sub", OP_SUB, 7);
        run_r("orr", OP_ORR, 8);

        step("to_ok.1", OP_AND, 1'b0, 1'b0, S_FETCH, C_FETCH_W);
        step("to_ok.2", OP_AND, 1'b0, 1'b0, S_FETCH, C_FETCH_W);
        step("to_ok.3", OP_AND, 1'b0, 1'b0, S_FETCH, C_FETCH_W);
        step("to_ok.4", OP_AND, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step("to_ok.d", OP_AND, 1'b0, 1'b1, S_DECODE, C_DEC);
        step("to_ok.x", OP_AND, 1'b0, 1'b1, S_EXEC_R, C_EXEC_R);
        step("to_ok.w", OP_AND, 1'b0, 1'b1, S_WB_R, C_WB_R);
        ret_after("to_ok", 9);

        for (int i = 0; i < 4; i++)
            step("to.w", OP_ADD, 1'b0, 1'b0, S_FETCH, C_FETCH_W);
        for (int i = 0; i < 3; i++)
            step("to.flt", OP_ADD, 1'b0, 1'b1, S_FAULT, C_FAULT);
        chk("to.ret", 32'(retired), 32'd9);

        pulse_reset("rst1");
        run_b("b1", 1);
        step("bad.f", OP_BAD, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step("bad.d", OP_BAD, 1'b0, 1'b1, S_DECODE, C_DEC);
        for (int i = 0; i < 20; i++)
            step("bad.flt", OP_BAD, 1'b0, 1'b1, S_FAULT, C_FAULT);
        chk("bad.ret", 32'(retired), 32'd1);

        pulse_reset("rst2");
        for (int i = 0; i < 16; i++)
            run_b("wrap", (i + 1) % 16);
        run_b("b2", 1);

        step("abt.f", OP_STUR, 1'b0, 1'b1, S_FETCH, C_FETCH_A);
        step("abt.d", OP_STUR, 1'b0, 1'b1, S_DECODE, C_DEC_RL);
        step("abt.a", OP_STUR, 1'b0, 1'b0, S_ADDR, C_ADDR);
        step("abt.m", OP_STUR, 1'b0, 1'b0, S_MEM_WR, C_MEM_WR);
        pulse_reset("abt.rst");
        chk("abt.we", 32'(mem_we), 32'd0);

        run_r("add2", OP_ADD, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
